// File: rtl/instr_queue_pkg.sv
// Shared packet types and sizing constants for the fetch-to-decode instruction queue.
// No logic; types only.
// Imported by the queue and by anything that produces or consumes fetch packets.
package instr_queue_pkg;

    // Default number of queue entries; must be a power of two, >= 2
    localparam int IQ_DEPTH = 8;

    // One fetched instruction together with its branch-prediction metadata
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;

endpackage

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode/issue; discards all entries on mispredict flush.
// Latency: an entry enqueued in cycle N is first visible on pipe_out in cycle N+1 (no bypass).
// Backpressure: fetch_enable = !full, taken from registered count only (no deq_ready -> fetch path).
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  pipe_in_t                 pipe_in,
    output logic                     fetch_enable,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output pipe_in_t                 pipe_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pipe_in_t        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;

    // Occupancy flags and handshakes; full/empty look only at the registered count
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        fetch_enable = !full;
        deq_valid    = !empty;
        enq          = fetch_valid & !full;
        deq          = deq_valid & deq_ready;
        pipe_out     = mem[head];
    end

    // Pointer and occupancy update; reset clears storage, flush only drops the pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                mem[tail] <= pipe_in;
                tail      <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Occupancy never exceeds the storage size
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

    // A write must never land on an occupied slot
    a_no_enq_full: assert property (@(posedge clk) disable iff (reset)
        !(enq && full));

    // Head must never advance past the tail
    a_no_deq_empty: assert property (@(posedge clk) disable iff (reset)
        !(deq && empty));

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       fetch_valid;
    pipe_in_t   pipe_in;
    logic       fetch_enable;
    logic       deq_valid;
    logic       deq_ready;
    pipe_in_t   pipe_out;
    logic [3:0] count;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int tb_cnt    = 0;
    pipe_in_t exp_q[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .pipe_in      (pipe_in),
        .fetch_enable (fetch_enable),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .pipe_out     (pipe_out),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic pipe_in_t mk(input logic [31:0] pc);
        pipe_in_t p;
        p.pc          = pc;
        p.instruction = {pc[15:0], 16'h0013};
        p.prediction  = pc[2];
        p.branch      = pc[3];
        p.jump        = pc[4];
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Compare visible status against the bench's own occupancy model
    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 128'(count), 128'(tb_cnt));
        chk({tag, ".deq_valid"}, 128'(deq_valid), 128'(tb_cnt != 0));
        chk({tag, ".fetch_enable"}, 128'(fetch_enable), 128'(tb_cnt != DEPTH));
    endtask

    // One clock cycle of stimulus; expected entries are pushed when the model says they are accepted
    task automatic cyc(input logic fv, input pipe_in_t pkt, input logic dr,
                       input logic fl = 1'b0, input logic rs = 1'b0);
        bit acc;
        bit dq;
        fetch_valid = fv;
        pipe_in     = pkt;
        deq_ready   = dr;
        flush       = fl;
        reset       = rs;
        acc = fv && (tb_cnt != DEPTH) && !fl && !rs;
        dq  = dr && (tb_cnt != 0) && !fl && !rs;
        if (acc) exp_q.push_back(pkt);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            tb_cnt = 0;
            exp_q.delete();
        end else begin
            tb_cnt = tb_cnt + int'(acc) - int'(dq);
        end
    endtask

    // Scoreboard monitor: every real dequeue must present the oldest expected packet
    always @(negedge clk) begin
        if (!reset && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL deq_unexpected: got pc 0x%0h expected no dequeue", pipe_out.pc);
            end else begin
                chk("deq_pkt", 128'(pipe_out), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        pipe_in_t special;
        logic [31:0] pc;
        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; deq_ready = 1'b0; pipe_in = '0;

        // Reset state
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst.count", 128'(count), 128'(0));
        chk("rst.deq_valid", 128'(deq_valid), 128'(0));
        chk("rst.fetch_enable", 128'(fetch_enable), 128'(1));
        chk("rst.pipe_out", 128'(pipe_out), 128'(0));

        // Three enqueues with no consumer
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'(i * 4)), 1'b0);
        chk("enq3.count", 128'(count), 128'(3));
        chk("enq3.head_pc", 128'(pipe_out.pc), 128'(32'h0));
        chk("enq3.deq_valid", 128'(deq_valid), 128'(1));
        chk("enq3.fetch_enable", 128'(fetch_enable), 128'(1));

        // Fill to 8, then a 9th packet must be refused
        for (int i = 3; i < 8; i++) cyc(1'b1, mk(32'(i * 4)), 1'b0);
        chk("full.count", 128'(count), 128'(8));
        chk("full.fetch_enable", 128'(fetch_enable), 128'(0));
        cyc(1'b1, mk(32'h20), 1'b0);
        chk("full9.count", 128'(count), 128'(8));
        chk("full9.head_pc", 128'(pipe_out.pc), 128'(32'h0));

        // Full with consumer: dequeue happens, enqueue blocked; freed slot taken next cycle
        cyc(1'b1, mk(32'h20), 1'b1);
        chk("fulldeq.count", 128'(count), 128'(7));
        chk("fulldeq.head_pc", 128'(pipe_out.pc), 128'(32'h4));
        cyc(1'b1, mk(32'h20), 1'b0);
        chk("refill.count", 128'(count), 128'(8));
        chk_state("refill");

        // Drain in order (0x4..0x1C, then 0x20), then dequeue attempt on empty
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("drain.count", 128'(count), 128'(0));
        cyc(1'b0, '0, 1'b1);
        chk_state("empty_deq");

        // Steady state at occupancy 4 with pointers wrapping
        pc = 32'h40;
        for (int i = 0; i < 4; i++) begin cyc(1'b1, mk(pc), 1'b0); pc += 4; end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, mk(pc), 1'b1);
            pc += 4;
            chk("steady.count", 128'(count), 128'(4));
        end
        chk_state("steady");

        // Flush at occupancy 5 with same-cycle enq/deq requests
        cyc(1'b1, mk(pc), 1'b0);
        chk("preflush.count", 128'(count), 128'(5));
        cyc(1'b1, mk(32'h300), 1'b1, 1'b1);
        chk("flush.count", 128'(count), 128'(0));
        chk("flush.deq_valid", 128'(deq_valid), 128'(0));
        chk("flush.fetch_enable", 128'(fetch_enable), 128'(1));
        cyc(1'b1, mk(32'h100), 1'b0);
        chk("postflush.head_pc", 128'(pipe_out.pc), 128'(32'h100));

        // Prediction/jump metadata passes through untouched
        special = '{pc: 32'h200, instruction: 32'h0000006F, prediction: 1'b1, branch: 1'b0, jump: 1'b1};
        cyc(1'b1, special, 1'b0);
        chk("special.count", 128'(count), 128'(2));
        cyc(1'b0, '0, 1'b1);
        chk("special.pipe_out", 128'(pipe_out), 128'(special));
        chk("special.jump", 128'(pipe_out.jump), 128'(1));

        // Reset mid-fill at occupancy 6
        pc = 32'h400;
        for (int i = 0; i < 5; i++) begin cyc(1'b1, mk(pc), 1'b0); pc += 4; end
        chk("midfill.count", 128'(count), 128'(6));
        cyc(1'b1, mk(pc), 1'b0, 1'b0, 1'b1);
        chk("midrst.count", 128'(count), 128'(0));
        chk("midrst.pipe_out", 128'(pipe_out), 128'(0));
        chk_state("midrst");

        cyc(1'b0, '0, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
